// File: rtl/uart_link_if.sv
// Byte streams between uart_link and the bootloader: received bytes out, bytes to send in.
interface uart_link_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    // master is the bootloader side, slave is the UART
    modport master (
        input  rx_valid, rx_data, tx_ready,
        output rx_ready, tx_valid, tx_data
    );
    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/uart_link.sv
// Full-duplex 8N1 UART with a valid/ready byte interface, line-break detection,
// framing-error and overrun pulses.
module uart_link #(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned BREAK_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        uart_tx,
    uart_link_if.slave  bus,
    output logic        break_detect,
    output logic        framing_error,
    output logic        overrun
);

    localparam int unsigned DIV     = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W   = $clog2(DIV);
    localparam int unsigned BRK_MAX = BREAK_BITS * DIV;
    localparam int unsigned BRK_W   = $clog2(BRK_MAX + 1);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIV / 2 - 1);
    localparam logic [BRK_W-1:0] BRK_LIM  = BRK_W'(BRK_MAX);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t        tx_state, tx_state_d;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]       tx_bit, tx_bit_d;
    logic [7:0]       tx_shift, tx_shift_d;
    logic             tx_line_d;
    logic             tx_rdy, tx_rdy_d;

    assign bus.tx_ready = tx_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
            tx_rdy   <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            uart_tx  <= tx_line_d;
            tx_rdy   <= tx_rdy_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + CNT_W'(1);
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_line_d  = uart_tx;
        tx_rdy_d   = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_d  = '0;
                tx_line_d = 1'b1;
                if (bus.tx_valid && tx_rdy) begin
                    tx_state_d = TX_START;
                    tx_shift_d = bus.tx_data;
                    tx_bit_d   = '0;
                    tx_line_d  = 1'b0;
                end else begin
                    tx_rdy_d = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_END) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_line_d  = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift >> 1;
                        tx_line_d  = tx_shift[1];
                        tx_bit_d   = tx_bit + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_END) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                    tx_rdy_d   = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    logic             rx_meta, rxs, rxs_prev;
    rx_state_t        rx_state, rx_state_d;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]       rx_bit, rx_bit_d;
    logic [7:0]       rx_shift, rx_shift_d;
    logic             byte_done;
    logic             rx_vld, rx_vld_d;
    logic [7:0]       rx_byte, rx_byte_d;
    logic             framing_error_d, overrun_d;

    assign bus.rx_valid = rx_vld;
    assign bus.rx_data  = rx_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta       <= 1'b1;
            rxs           <= 1'b1;
            rxs_prev      <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_vld        <= 1'b0;
            rx_byte       <= '0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            rx_meta       <= uart_rx;
            rxs           <= rx_meta;
            rxs_prev      <= rxs;
            rx_state      <= rx_state_d;
            rx_cnt        <= rx_cnt_d;
            rx_bit        <= rx_bit_d;
            rx_shift      <= rx_shift_d;
            rx_vld        <= rx_vld_d;
            rx_byte       <= rx_byte_d;
            framing_error <= framing_error_d;
            overrun       <= overrun_d;
        end
    end

    always_comb begin
        rx_state_d      = rx_state;
        rx_cnt_d        = rx_cnt + CNT_W'(1);
        rx_bit_d        = rx_bit;
        rx_shift_d      = rx_shift;
        byte_done       = 1'b0;
        framing_error_d = 1'b0;
        overrun_d       = 1'b0;
        rx_vld_d        = rx_vld;
        rx_byte_d       = rx_byte;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rxs_prev && !rxs) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxs, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_d = RX_STOP;
                    else                rx_bit_d   = rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_d = '0;
                    if (rxs) begin
                        byte_done  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        framing_error_d = 1'b1;
                        rx_state_d      = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                // a held-low line must return high before another start bit counts
                rx_cnt_d = '0;
                if (rxs) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase

        if (rx_vld && bus.rx_ready) rx_vld_d = 1'b0;
        if (byte_done) begin
            if (!rx_vld || bus.rx_ready) begin
                rx_vld_d  = 1'b1;
                rx_byte_d = rx_shift;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // ---------------- break detector ----------------
    logic [BRK_W-1:0] brk_cnt, brk_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            brk_cnt      <= '0;
            break_detect <= 1'b0;
        end else begin
            brk_cnt      <= brk_cnt_d;
            break_detect <= (brk_cnt_d == BRK_LIM);
        end
    end

    always_comb begin
        brk_cnt_d = brk_cnt;
        if (rxs)                   brk_cnt_d = '0;
        else if (brk_cnt != BRK_LIM) brk_cnt_d = brk_cnt + BRK_W'(1);
    end

endmodule

// File: tb/tb_uart_link.sv
// Scoreboard bench for uart_link at DIV=16, BREAK_BITS=12: TX framing, RX stream,
// backpressure/overrun, glitch, framing error, break and mid-frame reset.
module tb_uart_link;

    logic clk = 1'b0;
    logic reset;
    logic uart_rx;
    logic uart_tx;
    logic break_detect;
    logic framing_error;
    logic overrun;

    uart_link_if bus();

    uart_link #(.CLK_FREQ(1600000), .BAUD(100000), .BREAK_BITS(12)) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .bus           (bus),
        .break_detect  (break_detect),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int ov_cyc = -1;
    int brk_rise = -1;
    int brk_fall = -1;
    logic brk_prev = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(16);
        end
        uart_rx = stop;
        tick(16);
        uart_rx = 1'b1;
    endtask

    task automatic wait_tx_ready();
        for (int i = 0; i < 400; i++) begin
            if (bus.tx_ready) break;
            tick(1);
        end
        check("tx_ready_wait", 32'(bus.tx_ready), 32'd1);
    endtask

    // Sends one byte and checks the first and last cycle of every bit cell.
    task automatic tx_frame_check(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        wait_tx_ready();
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
        for (int c = 1; c <= 160; c++) begin
            if ((c % 16 == 1) || (c % 16 == 0)) begin
                check("tx_bit", 32'(uart_tx), 32'(fr[(c - 1) / 16]));
                check("tx_ready_busy", 32'(bus.tx_ready), 32'd0);
            end
            tick(1);
        end
        check("tx_ready_return", 32'(bus.tx_ready), 32'd1);
        check("tx_idle_line", 32'(uart_tx), 32'd1);
    endtask

    // Output-side monitor: pops the scoreboard on every accepted byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid && bus.rx_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) check("rx_q_empty", 32'(exp_q.size()), 32'd1);
                else                   check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
            end
            if (framing_error) fe_cnt++;
            if (overrun) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
            if (break_detect && !brk_prev) brk_rise = cyc;
            if (!break_detect && brk_prev) brk_fall = cyc;
            brk_prev = break_detect;
        end
    end

    initial begin
        int a0, f0, o0, fcyc, gcyc, lows;
        reset        = 1'b1;
        uart_rx      = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.rx_ready = 1'b1;
        tick(3);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_break", 32'(break_detect), 32'd0);
        check("rst_framing", 32'(framing_error), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick(1);
        check("tx_ready_after_reset", 32'(bus.tx_ready), 32'd1);

        // TX 0xA5 while RX takes 0x3C at the same time
        fork
            tx_frame_check(8'hA5);
            begin
                a0 = acc_cnt;
                f0 = fe_cnt;
                exp_q.push_back(8'h3C);
                send_frame(8'h3C, 1'b1);
                tick(40);
                check("rx_3c_count", 32'(acc_cnt - a0), 32'd1);
                check("rx_3c_no_fe", 32'(fe_cnt - f0), 32'd0);
            end
        join

        // backpressure: 0x22 is dropped while 0x11 is held
        bus.rx_ready = 1'b0;
        a0 = acc_cnt;
        o0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        fcyc = cyc;
        send_frame(8'h22, 1'b1);
        tick(40);
        check("bp_valid_held", 32'(bus.rx_valid), 32'd1);
        check("bp_data_held", 32'(bus.rx_data), 32'h11);
        check("bp_overrun_count", 32'(ov_cnt - o0), 32'd1);
        check("bp_overrun_cycle", 32'(ov_cyc), 32'(fcyc + 155));
        check("bp_no_accept", 32'(acc_cnt - a0), 32'd0);
        bus.rx_ready = 1'b1;
        tick(1);
        check("bp_valid_drop", 32'(bus.rx_valid), 32'd0);
        check("bp_accept", 32'(acc_cnt - a0), 32'd1);

        // glitch then bad stop bit
        a0 = acc_cnt;
        f0 = fe_cnt;
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(40);
        check("glitch_no_byte", 32'(acc_cnt - a0), 32'd0);
        check("glitch_no_fe", 32'(fe_cnt - f0), 32'd0);
        send_frame(8'h55, 1'b0);
        tick(40);
        check("fe_pulse", 32'(fe_cnt - f0), 32'd1);
        check("fe_no_byte", 32'(acc_cnt - a0), 32'd0);

        // break: 400 low cycles
        a0 = acc_cnt;
        f0 = fe_cnt;
        fcyc = cyc;
        uart_rx = 1'b0;
        tick(400);
        gcyc = cyc;
        uart_rx = 1'b1;
        tick(40);
        check("brk_rise", 32'(brk_rise), 32'(fcyc + 194));
        check("brk_fall", 32'(brk_fall), 32'(gcyc + 3));
        check("brk_fe_once", 32'(fe_cnt - f0), 32'd1);
        check("brk_no_byte", 32'(acc_cnt - a0), 32'd0);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        tick(40);
        check("post_brk_byte", 32'(acc_cnt - a0), 32'd1);

        // reset during data bit 3 of 0x00
        wait_tx_ready();
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
        tick(69);
        check("rst_tx_bit3_low", 32'(uart_tx), 32'd0);
        reset = 1'b1;
        tick(1);
        check("rst_mid_line", 32'(uart_tx), 32'd1);
        check("rst_mid_ready", 32'(bus.tx_ready), 32'd0);
        tick(2);
        check("rst_hold_ready", 32'(bus.tx_ready), 32'd0);
        reset = 1'b0;
        tick(1);
        check("rst_release_ready", 32'(bus.tx_ready), 32'd1);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (!uart_tx) lows++;
            tick(1);
        end
        check("no_resumed_frame", 32'(lows), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
